// File: rtl/conv_pkg.sv
// Shared constants and state encoding for the convolution-engine input streamer.
package conv_pkg;

    localparam int IMG_W     = 14;
    localparam int K         = 3;
    localparam int DW        = 16;
    localparam int AW        = 8;
    localparam int DRAIN_MAX = 512;

    localparam int N_IFM = IMG_W * IMG_W;
    localparam int N_W   = K * K;
    localparam int N_OFM = (IMG_W - K + 1) * (IMG_W - K + 1);

    localparam int CW  = 8;
    localparam int DCW = $clog2(DRAIN_MAX) + 1;
    localparam int WIW = $clog2(N_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SEND  = 2'b01,
        ST_DRAIN = 2'b10
    } state_t;

    function automatic logic addr_in_range(input logic sel, input logic [AW-1:0] addr);
        return sel ? (addr < AW'(N_W)) : (addr < AW'(N_IFM));
    endfunction

endpackage

// File: rtl/conv_stream_tx_if.sv
// Stream bus between the transmitter (master) and the convolution engine (slave).
interface conv_stream_tx_if;
    import conv_pkg::*;

    logic          conv_in_valid;
    logic [DW-1:0] conv_ifm;
    logic [DW-1:0] conv_weight;
    logic          conv_out_valid;

    modport master (
        output conv_in_valid,
        output conv_ifm,
        output conv_weight,
        input  conv_out_valid
    );

    modport slave (
        input  conv_in_valid,
        input  conv_ifm,
        input  conv_weight,
        output conv_out_valid
    );

endinterface

// File: rtl/conv_tx_fsm.sv
// Sequencer for one frame: beat counter during SEND, output/drain counting until done or timeout.
//  state    | meaning
//  ST_IDLE  | waiting for start; host may write buffers
//  ST_SEND  | one IFM beat per cycle, beat_cnt = beat currently on the bus
//  ST_DRAIN | bus quiet, waiting for remaining engine outputs or DRAIN_MAX cycles
module conv_tx_fsm
    import conv_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          conv_out_valid,
    output logic          send_load,
    output logic [CW-1:0] beat_nxt,
    output logic          busy,
    output logic          done,
    output logic          timeout
);

    localparam logic [CW-1:0]  LAST_BEAT = CW'(N_IFM - 1);
    localparam logic [CW-1:0]  OFM_TGT   = CW'(N_OFM);
    localparam logic [DCW-1:0] DRAIN_LIM = DCW'(DRAIN_MAX);

    state_t         state_q, state_d;
    logic [CW-1:0]  beat_cnt, beat_d;
    logic [CW-1:0]  out_cnt, out_d, out_inc;
    logic [DCW-1:0] drain_cnt, drain_d, drain_inc;
    logic           done_d, timeout_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            beat_cnt  <= '0;
            out_cnt   <= '0;
            drain_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_cnt  <= beat_d;
            out_cnt   <= out_d;
            drain_cnt <= drain_d;
            busy      <= (state_d != ST_IDLE);
            done      <= done_d;
            timeout   <= timeout_d;
        end
    end

    assign out_inc   = out_cnt + CW'(conv_out_valid);
    assign drain_inc = drain_cnt + DCW'(1);

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_cnt;
        out_d     = out_cnt;
        drain_d   = drain_cnt;
        done_d    = 1'b0;
        timeout_d = timeout;
        send_load = 1'b0;
        beat_nxt  = beat_cnt;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_SEND;
                    beat_d    = '0;
                    out_d     = '0;
                    drain_d   = '0;
                    timeout_d = 1'b0;
                    send_load = 1'b1;
                    beat_nxt  = '0;
                end
            end
            ST_SEND: begin
                // Engine produces outputs while still receiving, so count here too.
                out_d = out_inc;
                if (beat_cnt == LAST_BEAT) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end else begin
                    beat_d    = beat_cnt + CW'(1);
                    send_load = 1'b1;
                    beat_nxt  = beat_cnt + CW'(1);
                end
            end
            ST_DRAIN: begin
                out_d   = out_inc;
                drain_d = drain_inc;
                if (out_inc >= OFM_TGT) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (drain_inc == DRAIN_LIM) begin
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/conv_stream_tx.sv
// Frame/kernel buffers with host write port, streamed into the convolution engine on start.
module conv_stream_tx
    import conv_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic          wr_sel,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          start,
    conv_stream_tx_if.master conv,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic          wr_err
);

    logic [DW-1:0] ifm_mem [N_IFM];
    logic [DW-1:0] w_mem   [N_W];

    logic          send_load;
    logic [CW-1:0] beat_nxt;
    logic          wr_ok, wr_rej;
    logic [DW-1:0] ifm_rd, w_rd;

    conv_tx_fsm u_fsm (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .conv_out_valid (conv.conv_out_valid),
        .send_load      (send_load),
        .beat_nxt       (beat_nxt),
        .busy           (busy),
        .done           (done),
        .timeout        (timeout)
    );

    // Writes are frozen while busy so the frame on the wire cannot change.
    assign wr_ok  = wr_en && !busy && addr_in_range(wr_sel, wr_addr);
    assign wr_rej = wr_en && !wr_ok;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            if (wr_sel) w_mem[wr_addr[WIW-1:0]] <= wr_data;
            else        ifm_mem[wr_addr]        <= wr_data;
        end
    end

    // Forward a same-cycle write so beat 0 of a start sees the new word.
    always_comb begin
        ifm_rd = ifm_mem[beat_nxt];
        w_rd   = '0;
        if (wr_ok && !wr_sel && (wr_addr == beat_nxt)) ifm_rd = wr_data;
        if (beat_nxt < CW'(N_W)) begin
            w_rd = w_mem[beat_nxt[WIW-1:0]];
            if (wr_ok && wr_sel && (wr_addr == beat_nxt)) w_rd = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            conv.conv_in_valid <= 1'b0;
            conv.conv_ifm      <= '0;
            conv.conv_weight   <= '0;
            wr_err             <= 1'b0;
        end else begin
            wr_err             <= wr_rej;
            conv.conv_in_valid <= send_load;
            conv.conv_ifm      <= send_load ? ifm_rd : '0;
            conv.conv_weight   <= send_load ? w_rd   : '0;
        end
    end

endmodule
